// File: rtl/traffic_light_controller.sv
// Highway / farm-road intersection controller: a Moore FSM with cycle-count dwell
// timers and a sticky farm-road request, driving one-hot {red,yellow,green} lamps.
module traffic_light_controller #(
    parameter int unsigned HW_MIN_GREEN     = 5,
    parameter int unsigned YELLOW_TICKS     = 3,
    parameter int unsigned FARM_GREEN_TICKS = 10,
    parameter int unsigned CNT_W            = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor,
    output logic [2:0]       light_HW,
    output logic [2:0]       light_FM,
    output logic [1:0]       dbg_state,
    output logic [CNT_W-1:0] dbg_count,
    output logic             dbg_req
);

    typedef enum logic [1:0] {
        HG_FR = 2'd0,
        HY_FR = 2'd1,
        HR_FG = 2'd2,
        HR_FY = 2'd3
    } state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [CNT_W-1:0] HG_LAST = CNT_W'(HW_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] FG_LAST = CNT_W'(FARM_GREEN_TICKS - 1);

    if (HW_MIN_GREEN < 1 || YELLOW_TICKS < 1 || FARM_GREEN_TICKS < 1) begin : g_bad_ticks
        $error("traffic_light_controller: every tick parameter must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             req_flag;
    logic             req;

    // A request seen on this very edge counts, so a pulse never waits a cycle.
    assign req = req_flag | sensor;

    always_comb begin
        state_nxt = state;
        case (state)
            HG_FR:   if (count == HG_LAST && req) state_nxt = HY_FR;
            HY_FR:   if (count == Y_LAST)         state_nxt = HR_FG;
            HR_FG:   if (count == FG_LAST)        state_nxt = HR_FY;
            HR_FY:   if (count == Y_LAST)         state_nxt = HG_FR;
            default:                              state_nxt = HG_FR;
        endcase
    end

    function automatic logic [2:0] hw_lamp(input state_t s);
        case (s)
            HG_FR:   hw_lamp = LAMP_GREEN;
            HY_FR:   hw_lamp = LAMP_YELLOW;
            default: hw_lamp = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] fm_lamp(input state_t s);
        case (s)
            HR_FG:   fm_lamp = LAMP_GREEN;
            HR_FY:   fm_lamp = LAMP_YELLOW;
            default: fm_lamp = LAMP_RED;
        endcase
    endfunction

    // Lamps are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HG_FR;
            count    <= '0;
            req_flag <= 1'b0;
            light_HW <= LAMP_GREEN;
            light_FM <= LAMP_RED;
        end else begin
            state    <= state_nxt;
            light_HW <= hw_lamp(state_nxt);
            light_FM <= fm_lamp(state_nxt);

            if (state_nxt != state) begin
                count <= '0;
            end else if (!(state == HG_FR && count == HG_LAST)) begin
                count <= count + 1'b1;
            end

            // Starting farm green consumes the request; a sensor hit on that edge is a new one.
            if (state == HY_FR && state_nxt == HR_FG) begin
                req_flag <= sensor;
            end else if (sensor) begin
                req_flag <= 1'b1;
            end
        end
    end

    assign dbg_state = state;
    assign dbg_count = count;
    assign dbg_req   = req_flag;

    a_one_red : assert property (@(posedge clk) disable iff (reset)
        (light_HW == LAMP_RED) || (light_FM == LAMP_RED));

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: table-driven lamp vectors plus hand-written
// sequences, checked through an expected-value queue sampled on the falling edge.
module tb_traffic_light_controller;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk;
    logic       reset;
    logic       sensor;
    logic [2:0] light_HW;
    logic [2:0] light_FM;
    logic [1:0] dbg_state;
    logic [7:0] dbg_count;
    logic       dbg_req;

    int checks = 0;
    int errors = 0;

    // {check_count, count[7:0], hw[2:0], fm[2:0]}
    logic [14:0] exp_q[$];
    int          tag_q[$];
    int          cur_tag;

    typedef struct {
        logic       rst;
        logic       sen;
        int         reps;
        logic [2:0] hw;
        logic [2:0] fm;
    } vec_t;

    vec_t tbl[$];

    traffic_light_controller #(
        .HW_MIN_GREEN(5),
        .YELLOW_TICKS(3),
        .FARM_GREEN_TICKS(10),
        .CNT_W(8)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .sensor(sensor),
        .light_HW(light_HW),
        .light_FM(light_FM),
        .dbg_state(dbg_state),
        .dbg_count(dbg_count),
        .dbg_req(dbg_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input int n,
                                input logic [2:0] hw, input logic [2:0] fm);
        vec_t v;
        v.rst = r; v.sen = s; v.reps = n; v.hw = hw; v.fm = fm;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s tag=%0d actual=%0h expected=%0h", name, tag, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [2:0] hw, input logic [2:0] fm,
                        input logic chk, input logic [7:0] cnt);
        reset  = r;
        sensor = s;
        @(posedge clk);
        exp_q.push_back({chk, cnt, hw, fm});
        tag_q.push_back(cur_tag);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [14:0] e;
            int          t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check("light_HW", t, int'(light_HW), int'(e[5:3]));
            check("light_FM", t, int'(light_FM), int'(e[2:0]));
            check("one_red", t, int'(light_HW == R || light_FM == R), 1);
            if (e[14]) check("count", t, int'(dbg_count), int'(e[13:6]));
        end
    end

    initial begin
        int idle;
        reset   = 1'b1;
        sensor  = 1'b0;
        cur_tag = 0;
        idle    = int'($urandom_range(0, 20));

        // idle after reset, then a single pulse one cycle after reset
        tbl.push_back(mk(1, 0, 1,  G, R));
        tbl.push_back(mk(0, 0, 50, G, R));
        tbl.push_back(mk(1, 0, 1,  G, R));
        tbl.push_back(mk(0, 1, 1,  G, R));
        tbl.push_back(mk(0, 0, 3,  G, R));
        tbl.push_back(mk(0, 0, 3,  Y, R));
        tbl.push_back(mk(0, 0, 10, R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 9,  G, R));
        // long idle green: pulse is honoured on the next edge
        tbl.push_back(mk(0, 0, idle, G, R));
        tbl.push_back(mk(0, 1, 1,  Y, R));
        tbl.push_back(mk(0, 0, 2,  Y, R));
        tbl.push_back(mk(0, 0, 10, R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 10, G, R));
        // pulse during farm green: exactly min green, then a second farm cycle
        tbl.push_back(mk(0, 1, 1,  Y, R));
        tbl.push_back(mk(0, 0, 2,  Y, R));
        tbl.push_back(mk(0, 0, 3,  R, G));
        tbl.push_back(mk(0, 1, 1,  R, G));
        tbl.push_back(mk(0, 0, 6,  R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 5,  G, R));
        tbl.push_back(mk(0, 0, 3,  Y, R));
        tbl.push_back(mk(0, 0, 10, R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 8,  G, R));
        // sensor on the yellow-to-farm-green edge is kept as a new request
        tbl.push_back(mk(0, 1, 1,  Y, R));
        tbl.push_back(mk(0, 0, 2,  Y, R));
        tbl.push_back(mk(0, 1, 1,  R, G));
        tbl.push_back(mk(0, 0, 9,  R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 5,  G, R));
        tbl.push_back(mk(0, 0, 3,  Y, R));
        tbl.push_back(mk(0, 0, 10, R, G));
        tbl.push_back(mk(0, 0, 3,  R, Y));
        tbl.push_back(mk(0, 0, 6,  G, R));

        for (int v = 0; v < tbl.size(); v++) begin
            cur_tag = v;
            for (int n = 0; n < tbl[v].reps; n++) begin
                step(tbl[v].rst, tbl[v].sen, tbl[v].hw, tbl[v].fm, 1'b0, 8'd0);
            end
        end

        // sensor held high from a saturated highway green: period 5+3+10+3
        cur_tag = 100;
        for (int n = 0; n < 63; n++) begin
            int p;
            p = (5 + n) % 21;
            if (p < 5)       step(0, 1, G, R, 1'b0, 8'd0);
            else if (p < 8)  step(0, 1, Y, R, 1'b0, 8'd0);
            else if (p < 18) step(0, 1, R, G, 1'b0, 8'd0);
            else             step(0, 1, R, Y, 1'b0, 8'd0);
        end

        // reset in the middle of farm green with a request pending
        cur_tag = 200;
        step(1, 0, G, R, 1'b1, 8'd0);
        step(0, 1, G, R, 1'b1, 8'd1);
        for (int i = 2; i <= 4; i++) step(0, 0, G, R, 1'b1, 8'(i));
        for (int i = 0; i <= 2; i++) step(0, 0, Y, R, 1'b1, 8'(i));
        for (int i = 0; i <= 2; i++) step(0, 0, R, G, 1'b1, 8'(i));
        step(0, 1, R, G, 1'b1, 8'd3);
        cur_tag = 201;
        step(1, 0, G, R, 1'b1, 8'd0);
        for (int i = 1; i <= 20; i++) step(0, 0, G, R, 1'b1, 8'((i < 4) ? i : 4));

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_controller.md
Name: traffic_light_controller

Overview:
- Moore-FSM traffic light controller for a highway / farm-road intersection.
- The highway holds green by default. A vehicle sensor on the farm road requests a farm-road green phase.
- The block sequences highway yellow, farm green, farm yellow, then back to highway green, with cycle-count dwell timers.
- It drives two 3-bit lamp outputs directly to the signal heads.

Parameters:
- HW_MIN_GREEN, 5: minimum highway-green dwell in clock cycles before a farm request is honoured (≥1).
- YELLOW_TICKS, 3: dwell of each yellow phase in cycles (≥1).
- FARM_GREEN_TICKS, 10: dwell of farm-road green in cycles (≥1).
- CNT_W, 8: dwell counter width. Every tick parameter must be ≤ 2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- sensor  input  1  farm-road vehicle detect; level, sampled on the rising edge.
- light_HW  output  3  highway lamp, encoded {red,yellow,green}: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- light_FM  output  3  farm-road lamp, same encoding.

Behaviour:
- One clock domain. Reset is synchronous and active-high. reset=1 at a rising edge forces:
  - state = HG_FR (highway green, farm red);
  - dwell counter = 0;
  - request flag = 0.
- Reset overrides everything, including mid-phase. Lamps show light_HW=3'b001, light_FM=3'b100 from the cycle after that edge.
- States and lamp outputs (outputs are a pure decode of the state register, no extra latency):
  - HG_FR: HW=001, FM=100
  - HY_FR: HW=010, FM=100
  - HR_FG: HW=100, FM=001
  - HR_FY: HW=100, FM=010
- Safety invariant: at least one lamp is RED in every cycle. Only the one-hot values listed above ever appear on the outputs.
- Dwell counter:
  - increments every cycle while the state is unchanged;
  - clears to 0 on every state transition;
  - in HG_FR it saturates at HW_MIN_GREEN-1.
- Request flag:
  - set on any edge where sensor=1 (outside reset);
  - cleared on the transition HY_FR→HR_FG;
  - sensor=1 on that same edge re-sets it, so a new request is taken;
  - sticky, so a one-cycle sensor pulse is never lost.
- Transitions (evaluated each rising edge, reset=0). "req" is the request flag OR sensor sampled on that edge.
  - HG_FR→HY_FR when counter==HW_MIN_GREEN-1 and req. Otherwise stay; highway green is held indefinitely without a request.
  - HY_FR→HR_FG when counter==YELLOW_TICKS-1.
  - HR_FG→HR_FY when counter==FARM_GREEN_TICKS-1. Farm green is fixed length; sensor does not extend it.
  - HR_FY→HG_FR when counter==YELLOW_TICKS-1.
- Resulting phase lengths:
  - highway green ≥ HW_MIN_GREEN cycles;
  - each yellow exactly YELLOW_TICKS cycles;
  - farm green exactly FARM_GREEN_TICKS cycles.
- Back-to-back requests:
  - a sensor assertion during HR_FG or HR_FY leaves the flag set;
  - after returning, highway green still lasts exactly HW_MIN_GREEN cycles, then a new farm cycle starts.
- With parameters equal to 1: HG_FR exits on the first edge where req is seen; each timed state lasts one cycle.
- No X-propagation on outputs after the first reset edge. Before the first reset, the state is undefined.

Test Plan:
- Reset, no sensor: hold reset=1 one edge, then reset=0 for 50 cycles -> light_HW=001, light_FM=100 every cycle; no transitions.
- Single-cycle sensor pulse one cycle after reset (defaults), taking cycle 0 as the first cycle after reset release -> HW=001 cycles 0–4, HW=010 cycles 5–7, FM=001 cycles 8–17, FM=010 cycles 18–20, HW=001 from cycle 21; FM=100 whenever HW≠100.
- Sensor pulse at cycle 30 after a long idle green -> HY_FR entered on the very next edge (min green already satisfied); yellow lasts 3 cycles, then farm green 10 cycles.
- Sensor pulsed during farm green -> after farm yellow, highway green lasts exactly 5 cycles, then a second HY_FR/HR_FG cycle runs.
- Sensor held high continuously -> steady repeating period of 5+3+10+3=21 cycles; both lamps are never non-red together.
- Reset asserted mid HR_FG -> next cycle HW=001, FM=100, counter 0; a pending request is cleared, so no new farm cycle without a fresh sensor assertion.
